pe_wave_ctrl: RTL and testbench

Run controller for a linear chain of `NUM_PE` pass-through PE tiles. Each tile registers its inputs only while its `ap_start` is high and holds its outputs otherwise. The block turns a single host `start` into a staggered enable wavefront: tile i is enabled i cycles after tile 0 and stays enabled for `run_len` issue cycles. It supports global stall, then reports completion. It sits beside the tile chain and drives every tile's `ap_start`.

---
 rtl/pe_ctrl_pkg.sv | 14 +
 rtl/pe_wave_ctrl_if.sv | 25 ++
 rtl/pe_wave_mask.sv | 18 +
 rtl/pe_wave_ctrl.sv | 101 ++++++++++
 tb/tb_pe_wave_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for tile-array run controllers: FSM state encoding and default counter width.
package pe_ctrl_pkg;

  localparam int unsigned PE_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } pe_state_e;

endpackage : pe_ctrl_pkg

// File: rtl/pe_wave_ctrl_if.sv
// Host-side control bus of the PE wavefront controller plus the per-tile enable fan-out.
interface pe_wave_ctrl_if #(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned CNT_W  = 16
);

  logic              start;
  logic [CNT_W-1:0]  run_len;
  logic              stall;
  logic [NUM_PE-1:0] ap_start;
  logic              busy;
  logic              done;
  logic [CNT_W:0]    phase;

  modport master (
    output start, run_len, stall,
    input  ap_start, busy, done, phase
  );

  modport slave (
    input  start, run_len, stall,
    output ap_start, busy, done, phase
  );

endinterface : pe_wave_ctrl_if

// File: rtl/pe_wave_mask.sv
// Wavefront enable mask: tile i is active for phases i .. i+len-1.
module pe_wave_mask #(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic [CNT_W:0]    i_k,
  input  logic [CNT_W-1:0]  i_len,
  output logic [NUM_PE-1:0] o_mask
);

  localparam int unsigned KW = CNT_W + 1;

  // One extra bit keeps i+len from wrapping for any legal len.
  for (genvar i = 0; i < int'(NUM_PE); i++) begin : g_tile
    assign o_mask[i] = (i_k >= KW'(i)) && (i_k < (KW'(i) + KW'(i_len)));
  end

endmodule : pe_wave_mask

// File: rtl/pe_wave_ctrl.sv
// Run controller turning a host start into a staggered, stallable ap_start wavefront across NUM_PE tiles.
module pe_wave_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned CNT_W  = PE_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  pe_wave_ctrl_if.slave  bus
);

  localparam int unsigned KW = CNT_W + 1;

  pe_state_e         r_state;
  logic [KW-1:0]     r_k;
  logic [CNT_W-1:0]  r_len;
  logic [NUM_PE-1:0] r_ap_start;
  logic              r_done;

  pe_state_e         w_state_nxt;
  logic [KW-1:0]     w_k_nxt;
  logic [CNT_W-1:0]  w_len_nxt;
  logic [NUM_PE-1:0] w_ap_nxt;
  logic              w_done_nxt;
  logic [NUM_PE-1:0] w_mask;
  logic [KW-1:0]     w_k_inc;
  logic [KW-1:0]     w_end;

  pe_wave_mask #(
    .NUM_PE (NUM_PE),
    .CNT_W  (CNT_W)
  ) u_mask (
    .i_k    (r_k),
    .i_len  (r_len),
    .o_mask (w_mask)
  );

  assign w_k_inc = r_k + KW'(1);
  // Last issue happens at k = len+NUM_PE-2, so k' reaching len+NUM_PE-1 ends the run.
  assign w_end   = KW'(r_len) + KW'(NUM_PE - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_len      <= '0;
      r_ap_start <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_len      <= w_len_nxt;
      r_ap_start <= w_ap_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_len_nxt   = r_len;
    w_ap_nxt    = '0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.run_len != '0) begin
            w_len_nxt   = bus.run_len;
            w_k_nxt     = '0;
            w_state_nxt = ST_FILL;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_FILL, ST_RUN, ST_DRAIN: begin
        // A stalled cycle issues nothing and keeps the wavefront position.
        if (!bus.stall) begin
          w_ap_nxt = w_mask;
          w_k_nxt  = w_k_inc;
          if (w_k_inc >= w_end)                w_state_nxt = ST_DONE;
          else if (w_k_inc >= KW'(r_len))      w_state_nxt = ST_DRAIN;
          else if (w_k_inc >= KW'(NUM_PE - 1)) w_state_nxt = ST_RUN;
          else                                 w_state_nxt = ST_FILL;
        end
      end
      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.ap_start = r_ap_start;
  assign bus.done     = r_done;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.phase    = r_k;

endmodule : pe_wave_ctrl

// File: tb/tb_pe_wave_ctrl.sv
// Directed bench for pe_wave_ctrl with NUM_PE=4: fill/drain, short runs, zero length, stall, reset and start filtering.
module tb_pe_wave_ctrl;
  import pe_ctrl_pkg::*;

  localparam int unsigned NUM_PE = 4;
  localparam int unsigned CNT_W  = 16;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [3:0] exp3 [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0] exp1 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] exp2 [5] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};

  pe_wave_ctrl_if #(.NUM_PE(NUM_PE), .CNT_W(CNT_W)) bus ();

  pe_wave_ctrl #(
    .NUM_PE (NUM_PE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the start cycle t; returns in cycle t+8 with done high.
  task automatic run_len3(input string tag);
    bus.run_len = 16'd3;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
    chk({tag, "_ap1"}, 32'(bus.ap_start), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("%s_ap%0d", tag, i), 32'(bus.ap_start), 32'(exp3[i]));
      chk($sformatf("%s_nodone%0d", tag, i), 32'(bus.done), 32'd0);
    end
    tick();
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ap_end"}, 32'(bus.ap_start), 32'd0);
    chk({tag, "_phase_end"}, 32'(bus.phase), 32'd6);
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.stall   = 1'b0;
    bus.run_len = '0;
    tick();
    tick();
    chk("rst_ap", 32'(bus.ap_start), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    reset = 1'b0;
    tick();

    // Basic run, len=3.
    run_len3("len3");
    tick();
    chk("len3_done_clr", 32'(bus.done), 32'd0);

    // len=1: FILL jumps straight to DRAIN.
    bus.run_len = 16'd1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("len1_ap%0d", i), 32'(bus.ap_start), 32'(exp1[i]));
      if (i < 3) chk($sformatf("len1_state%0d", i), 32'(dut.r_state), 32'(ST_DRAIN));
    end
    tick();
    chk("len1_done", 32'(bus.done), 32'd1);
    chk("len1_ap_end", 32'(bus.ap_start), 32'd0);
    chk("len1_phase", 32'(bus.phase), 32'd4);
    tick();

    // len=0: no enables, done two cycles after start.
    bus.run_len = 16'd0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("len0_busy", 32'(bus.busy), 32'd1);
    chk("len0_ap", 32'(bus.ap_start), 32'd0);
    chk("len0_nodone", 32'(bus.done), 32'd0);
    tick();
    chk("len0_done", 32'(bus.done), 32'd1);
    chk("len0_busy_end", 32'(bus.busy), 32'd0);
    chk("len0_ap_end", 32'(bus.ap_start), 32'd0);
    tick();
    chk("len0_done_clr", 32'(bus.done), 32'd0);

    // Stall for two cycles after the 0011 mask.
    bus.run_len = 16'd3;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("stall_ap0", 32'(bus.ap_start), 32'h1);
    tick();
    chk("stall_ap1", 32'(bus.ap_start), 32'h3);
    bus.stall = 1'b1;
    tick();
    chk("stall_z0", 32'(bus.ap_start), 32'h0);
    chk("stall_ph0", 32'(bus.phase), 32'd2);
    tick();
    bus.stall = 1'b0;
    chk("stall_z1", 32'(bus.ap_start), 32'h0);
    chk("stall_ph1", 32'(bus.phase), 32'd2);
    chk("stall_busy", 32'(bus.busy), 32'd1);
    for (int i = 2; i < 6; i++) begin
      tick();
      chk($sformatf("stall_ap%0d", i), 32'(bus.ap_start), 32'(exp3[i]));
      chk($sformatf("stall_nodone%0d", i), 32'(bus.done), 32'd0);
    end
    tick();
    chk("stall_done", 32'(bus.done), 32'd1);
    chk("stall_busy_end", 32'(bus.busy), 32'd0);
    chk("stall_phase", 32'(bus.phase), 32'd6);

    // Reset mid-run while mask is 0111, then a clean rerun.
    bus.run_len = 16'd3;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmid_pre", 32'(bus.ap_start), 32'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_ap", 32'(bus.ap_start), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    chk("rstmid_phase", 32'(bus.phase), 32'd0);
    run_len3("rerun");
    tick();

    // Start pulses mid-run and in DONE are ignored; the one in IDLE starts len=2.
    bus.run_len = 16'd1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("ign_ap0", 32'(bus.ap_start), 32'h1);
    tick();
    chk("ign_ap1", 32'(bus.ap_start), 32'h2);
    bus.run_len = 16'd0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign_ap2", 32'(bus.ap_start), 32'h4);
    tick();
    chk("ign_ap3", 32'(bus.ap_start), 32'h8);
    chk("ign_state_done", 32'(dut.r_state), 32'(ST_DONE));
    bus.run_len = 16'd2;
    bus.start   = 1'b1;
    tick();
    chk("ign_done", 32'(bus.done), 32'd1);
    chk("ign_busy_done", 32'(bus.busy), 32'd0);
    tick();
    bus.start = 1'b0;
    chk("new_busy", 32'(bus.busy), 32'd1);
    chk("new_ap_idle", 32'(bus.ap_start), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("new_ap%0d", i), 32'(bus.ap_start), 32'(exp2[i]));
    end
    tick();
    chk("new_done", 32'(bus.done), 32'd1);
    chk("new_phase", 32'(bus.phase), 32'd5);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pe_wave_ctrl
